// File: rtl/alu_cmd_sequencer.sv
// Command sequencer feeding the 4-bit accumulator ALU: buffers {rpt, op, operand} commands and issues one ALU op per clock.
// Optional shadow accumulator enabled by defining ALU_SEQ_SHADOW_EN.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_L,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [3:0]               cmd_operand,
  input  logic [1:0]               cmd_rpt,
  input  logic                     hold,
  input  logic                     flush,
  output logic [1:0]               op,
  output logic [3:0]               operand,
  output logic                     issue_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [3:0]               shadow_result
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic [1:0]    rem_q;
  logic [1:0]    cur_op_q;
  logic [3:0]    cur_operand_q;

  logic          fifo_empty, last, push, pop;
  logic [7:0]    head;

  assign fifo_empty  = (level_q == '0);
  assign cmd_ready   = (level_q < DEPTH_L);
  assign issue_valid = (state_q == ISSUE) & ~hold;
  assign last        = (rem_q == 2'd0);
  assign head        = mem_q[rd_ptr_q];
  assign push        = cmd_valid & cmd_ready & ~flush;
  // Pop either to start from IDLE or to chain the next command without a bubble.
  assign pop         = ~flush & ~fifo_empty & ((state_q == IDLE) | (issue_valid & last));
  assign level_d     = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign op      = issue_valid ? cur_op_q      : 2'b10;
  assign operand = issue_valid ? cur_operand_q : 4'h0;
  assign busy    = (state_q == ISSUE) | ~fifo_empty;
  assign level   = level_q;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rem_q    <= 2'd0;
    end else if (flush) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rem_q    <= 2'd0;
    end else begin
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= ISSUE;
            rem_q   <= head[7:6];
          end
        end
        ISSUE: begin
          if (issue_valid) begin
            if (!last)    rem_q   <= rem_q - 2'd1;
            else if (pop) rem_q   <= head[7:6];
            else          state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage and current-command registers carry data only; outputs are gated by issue_valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_rpt, cmd_op, cmd_operand};
    if (pop) begin
      cur_op_q      <= head[5:4];
      cur_operand_q <= head[3:0];
    end
  end

`ifdef ALU_SEQ_SHADOW_EN
  logic [3:0] shadow_q;

  // Mirrors the ALU accumulator; the ALU executes whatever is driven, flush or not.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      shadow_q <= 4'h0;
    end else if (issue_valid) begin
      case (cur_op_q)
        2'b00:   shadow_q <= shadow_q + cur_operand_q;
        2'b01:   shadow_q <= shadow_q - cur_operand_q;
        2'b10:   shadow_q <= shadow_q | cur_operand_q;
        default: shadow_q <= shadow_q ^ cur_operand_q;
      endcase
    end
  end

  assign shadow_result = shadow_q;
`else
  assign shadow_result = 4'h0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: accepted commands expand into an expected execution stream checked by a monitor.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_L, cmd_valid, cmd_ready, hold, flush, issue_valid, busy;
  logic [1:0] cmd_op, cmd_rpt, op;
  logic [3:0] cmd_operand, operand, shadow_result;
  logic [2:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] opd;
  } ex_t;

  ex_t        exq[$];
  logic [3:0] sh_m = 4'h0;

  alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_L(reset_L), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand), .cmd_rpt(cmd_rpt), .hold(hold),
    .flush(flush), .op(op), .operand(operand), .issue_valid(issue_valid),
    .busy(busy), .level(level), .shadow_result(shadow_result)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] alu(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
    case (o)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [3:0] exp_sh(input logic [3:0] v);
`ifdef ALU_SEQ_SHADOW_EN
    return v;
`else
    return 4'h0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    step();
    step();
    reset_L = 1'b1;
  endtask

  task automatic drive_cmd(input logic v, input logic [1:0] o, input logic [3:0] a, input logic [1:0] r);
    cmd_valid   = v;
    cmd_op      = o;
    cmd_operand = a;
    cmd_rpt     = r;
  endtask

  // Monitor: inputs are stable at the falling edge, so this sees exactly what the next rising edge will act on.
  always @(negedge clock) begin
    if (!reset_L) begin
      exq.delete();
      sh_m = 4'h0;
      chk("rst_iv", issue_valid, 0);
      chk("rst_op", op, 2);
      chk("rst_operand", operand, 0);
      chk("rst_level", level, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_shadow", shadow_result, 0);
    end else begin
      chk("shadow", shadow_result, exp_sh(sh_m));
      chk("busy", busy, exq.size() != 0);
      chk("ready_vs_level", cmd_ready, level < DEPTH);
      if (issue_valid === 1'b1) begin
        if (exq.size() == 0) begin
          chk("iv_spurious", issue_valid, 0);
        end else begin
          ex_t e;
          e = exq.pop_front();
          chk("issue_op", op, e.op);
          chk("issue_operand", operand, e.opd);
          sh_m = alu(e.op, sh_m, e.opd);
        end
      end else begin
        chk("nop_op", op, 2);
        chk("nop_operand", operand, 0);
      end
      if (flush) begin
        exq.delete();
      end else if (cmd_valid && cmd_ready) begin
        for (int r = 0; r <= int'(cmd_rpt); r++) begin
          ex_t e;
          e.op  = cmd_op;
          e.opd = cmd_operand;
          exq.push_back(e);
        end
      end
    end
  end

  initial begin
    int total, run, maxrun, k;
    reset_L = 1'b0;
    hold    = 1'b0;
    flush   = 1'b0;
    drive_cmd(1'b0, 2'b00, 4'h0, 2'd0);
    step();
    step();
    reset_L = 1'b1;
    step();

    // Reset in the middle of a stream with three commands buffered
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(1'b1, 2'(i), 4'(i + 2), 2'd1);
      step();
    end
    cmd_valid = 1'b0;
    chk("t1_pre_level", level, 3);
    #2 reset_L = 1'b0;
    #1;
    chk("t1_op", op, 2);
    chk("t1_operand", operand, 0);
    chk("t1_iv", issue_valid, 0);
    chk("t1_level", level, 0);
    chk("t1_ready", cmd_ready, 1);
    chk("t1_shadow", shadow_result, 0);
    step();
    hold    = 1'b0;
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t1_idle_after", issue_valid, 0);
      step();
    end

    // Single ADD: latency and one-cycle issue window
    drive_cmd(1'b1, 2'b00, 4'h3, 2'd0);
    step();
    cmd_valid = 1'b0;
    chk("t2_lat_iv", issue_valid, 0);
    chk("t2_level", level, 1);
    step();
    chk("t2_iv", issue_valid, 1);
    chk("t2_op", op, 0);
    chk("t2_operand", operand, 3);
    step();
    chk("t2_after_iv", issue_valid, 0);
    chk("t2_shadow", shadow_result, exp_sh(4'h3));

    // SUB with repeat 3 from a cleared accumulator
    do_reset();
    drive_cmd(1'b1, 2'b01, 4'h1, 2'd3);
    step();
    cmd_valid = 1'b0;
    step();
    total = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 8; i++) begin
      if (issue_valid) begin total++; run++; if (run > maxrun) maxrun = run; end
      else run = 0;
      step();
    end
    chk("t3_count", total, 4);
    chk("t3_run", maxrun, 4);
    chk("t3_shadow", shadow_result, exp_sh(4'hC));

    // Fill under hold, then back-to-back drain
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_cmd(1'b1, 2'b00, 4'(i + 1), 2'd0);
      if (i == 5) begin
        chk("t4_ready", cmd_ready, 0);
        chk("t4_level", level, 4);
      end
      chk("t4_iv_hold", issue_valid, 0);
      step();
    end
    cmd_valid = 1'b0;
    hold      = 1'b0;
    #1;
    total = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 10; i++) begin
      if (issue_valid) begin total++; run++; if (run > maxrun) maxrun = run; end
      else run = 0;
      step();
    end
    chk("t4_count", total, 5);
    chk("t4_run", maxrun, 5);
    chk("t4_shadow", shadow_result, exp_sh(4'hF));

    // XOR repeat 2 with a hold after the first issue
    do_reset();
    drive_cmd(1'b1, 2'b11, 4'h5, 2'd2);
    step();
    cmd_valid = 1'b0;
    step();
    chk("t5_first", issue_valid, 1);
    step();
    hold = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_iv", issue_valid, 0);
      step();
    end
    hold = 1'b0;
    #1;
    total = 0;
    for (int i = 0; i < 6; i++) begin
      if (issue_valid) total++;
      step();
    end
    chk("t5_count", total, 2);
    chk("t5_shadow", shadow_result, exp_sh(4'h5));

    // Flush in ISSUE with two buffered and a simultaneous push
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(1'b1, 2'b00, 4'h1, 2'd1);
      step();
    end
    chk("t6_pre_level", level, 2);
    flush = 1'b1;
    drive_cmd(1'b1, 2'b11, 4'hF, 2'd3);
    step();
    flush     = 1'b0;
    cmd_valid = 1'b0;
    hold      = 1'b0;
    #1;
    chk("t6_level", level, 0);
    chk("t6_busy", busy, 0);
    chk("t6_iv", issue_valid, 0);
    chk("t6_op", op, 2);
    chk("t6_shadow", shadow_result, exp_sh(4'h5));
    for (int i = 0; i < 4; i++) begin
      chk("t6_dropped", issue_valid, 0);
      step();
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      hold  = ($urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 49) == 0);
      if (flush) hold = 1'b1;
      step();
    end

    cmd_valid = 1'b0;
    hold      = 1'b0;
    flush     = 1'b0;
    k = 0;
    while (busy && k < 200) begin
      step();
      k++;
    end
    chk("drain_timeout", busy, 0);
    step();
    chk("drain_queue", exq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
